// File: rtl/spi_sd_responder.sv
// Card-side SPI mode-0 responder for the DivMMC SD link: oversamples the SPI pins,
// deframes 6-byte SD commands and shifts back host-supplied response bytes after Ncr.
module spi_sd_responder #(
    parameter int NCR_BYTES    = 1,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [7:0]  rx_byte,
    output logic        rx_strobe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [6:0]  cmd_crc,
    output logic        frame_err,
    input  logic [7:0]  resp_data,
    input  logic        resp_valid,
    input  logic        resp_last,
    output logic        resp_ready
);

    typedef enum logic [2:0] {HUNT, ARG, CRC, NCR, RESP} state_t;

    state_t      state_q, state_d;
    logic        sck_s1_q, sck_s2_q, sck_prev_q;
    logic        cs_n_s1_q, cs_n_s2_q, cs_n_prev_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [7:0]  tx_next_q, tx_next_d;
    logic        load_pending_q, load_pending_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_sr_q, arg_sr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_strobe_q, rx_strobe_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        resp_ready_q, resp_ready_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [6:0]  cmd_crc_q, cmd_crc_d;

    logic       cs_active, cs_assert, cs_deassert;
    logic       sck_rise, sck_fall, byte_done, resp_slot;
    logic [7:0] rx_shift, wait_cnt;

    assign cs_active   = !cs_n_s2_q;
    assign cs_assert   = cs_n_prev_q && !cs_n_s2_q;
    assign cs_deassert = !cs_n_prev_q && cs_n_s2_q;
    assign sck_rise    = cs_active && sck_s2_q && !sck_prev_q;
    assign sck_fall    = cs_active && !sck_s2_q && sck_prev_q;
    assign rx_shift    = {rx_sr_q, mosi_s2_q};
    assign byte_done   = sck_rise && (bit_cnt_q == 3'd7);

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        tx_next_d      = tx_next_q;
        load_pending_d = load_pending_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        arg_sr_d       = arg_sr_q;
        rx_byte_d      = rx_byte_q;
        rx_strobe_d    = 1'b0;
        cmd_valid_d    = 1'b0;
        frame_err_d    = 1'b0;
        resp_ready_d   = 1'b0;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;
        cmd_crc_d      = cmd_crc_q;
        resp_slot      = 1'b0;
        wait_cnt       = (state_q == NCR) ? 8'd0 : cnt_q;

        if (cs_deassert) begin
            bit_cnt_d      = 3'd0;
            load_pending_d = 1'b0;
            tx_sr_d        = 8'hFF;
            state_d        = HUNT;
        end else begin
            if (cs_assert) begin
                tx_sr_d   = 8'hFF;
                bit_cnt_d = 3'd0;
            end
            if (sck_rise) begin
                rx_sr_d   = rx_shift[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (sck_fall) begin
                if (load_pending_q) begin
                    tx_sr_d        = tx_next_q;
                    load_pending_d = 1'b0;
                end else begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b1};
                end
            end
            // Byte boundary: decide what the next slot carries and advance the deframer.
            if (byte_done) begin
                rx_byte_d      = rx_shift;
                rx_strobe_d    = 1'b1;
                load_pending_d = 1'b1;
                tx_next_d      = 8'hFF;
                case (state_q)
                    HUNT: if (rx_shift[7:6] == 2'b01) begin
                        idx_d   = rx_shift[5:0];
                        cnt_d   = 8'd0;
                        state_d = ARG;
                    end
                    ARG: begin
                        arg_sr_d = {arg_sr_q[23:0], rx_shift};
                        cnt_d    = cnt_q + 8'd1;
                        if (cnt_q == 8'd3) state_d = CRC;
                    end
                    CRC: if (rx_shift[0]) begin
                        cmd_index_d = idx_q;
                        cmd_arg_d   = arg_sr_q;
                        cmd_crc_d   = rx_shift[7:1];
                        cmd_valid_d = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = NCR;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                    NCR: begin
                        if (cnt_q == 8'(NCR_BYTES - 1)) resp_slot = 1'b1;
                        else cnt_d = cnt_q + 8'd1;
                    end
                    RESP:    resp_slot = 1'b1;
                    default: state_d = HUNT;
                endcase

                // The last Ncr slot already decides the first response slot.
                if (resp_slot) begin
                    state_d = RESP;
                    if (resp_valid) begin
                        tx_next_d    = resp_data;
                        resp_ready_d = 1'b1;
                        cnt_d        = 8'd0;
                        if (resp_last) state_d = HUNT;
                    end else begin
                        cnt_d = wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == 8'(RESP_TIMEOUT)) state_d = HUNT;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s1_q       <= 1'b0;
            sck_s2_q       <= 1'b0;
            sck_prev_q     <= 1'b0;
            cs_n_s1_q      <= 1'b1;
            cs_n_s2_q      <= 1'b1;
            cs_n_prev_q    <= 1'b1;
            mosi_s1_q      <= 1'b1;
            mosi_s2_q      <= 1'b1;
            state_q        <= HUNT;
            bit_cnt_q      <= 3'd0;
            rx_sr_q        <= 7'd0;
            tx_sr_q        <= 8'hFF;
            tx_next_q      <= 8'hFF;
            load_pending_q <= 1'b0;
            cnt_q          <= 8'd0;
            idx_q          <= 6'd0;
            arg_sr_q       <= 32'd0;
            rx_byte_q      <= 8'd0;
            rx_strobe_q    <= 1'b0;
            cmd_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            resp_ready_q   <= 1'b0;
            cmd_index_q    <= 6'd0;
            cmd_arg_q      <= 32'd0;
            cmd_crc_q      <= 7'd0;
        end else begin
            sck_s1_q       <= spi_sck;
            sck_s2_q       <= sck_s1_q;
            sck_prev_q     <= sck_s2_q;
            cs_n_s1_q      <= spi_cs_n;
            cs_n_s2_q      <= cs_n_s1_q;
            cs_n_prev_q    <= cs_n_s2_q;
            mosi_s1_q      <= spi_mosi;
            mosi_s2_q      <= mosi_s1_q;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_sr_q        <= rx_sr_d;
            tx_sr_q        <= tx_sr_d;
            tx_next_q      <= tx_next_d;
            load_pending_q <= load_pending_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            arg_sr_q       <= arg_sr_d;
            rx_byte_q      <= rx_byte_d;
            rx_strobe_q    <= rx_strobe_d;
            cmd_valid_q    <= cmd_valid_d;
            frame_err_q    <= frame_err_d;
            resp_ready_q   <= resp_ready_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
            cmd_crc_q      <= cmd_crc_d;
        end
    end

    assign spi_miso    = cs_active ? tx_sr_q[7] : 1'b1;
    assign spi_miso_oe = cs_active;
    assign rx_byte     = rx_byte_q;
    assign rx_strobe   = rx_strobe_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_index   = cmd_index_q;
    assign cmd_arg     = cmd_arg_q;
    assign cmd_crc     = cmd_crc_q;
    assign frame_err   = frame_err_q;
    assign resp_ready  = resp_ready_q;

endmodule
